// File: rtl/mac_rx_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_PORTS MAC RX byte streams into one
// header-buffer stream without interleaving frames. Optional mid-frame watchdog: ARB_WATCHDOG_EN.
module mac_rx_frame_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   in_valid,
   input  logic [8*NUM_PORTS-1:0] in_data,
   input  logic [NUM_PORTS-1:0]   in_last,
   output logic [NUM_PORTS-1:0]   in_ready,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   output logic                   out_last,
   output logic [IDX_W-1:0]       out_port,
   output logic                   out_err,
   input  logic                   out_ready,
   output logic                   busy
);

   if (NUM_PORTS < 2 || NUM_PORTS > 16 || (1 << IDX_W) < NUM_PORTS ||
       TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("mac_rx_frame_arbiter: unsupported parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1
`ifdef ARB_WATCHDOG_EN
      ,ABORT = 2'd2
`endif
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] gnt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             last_beat;
   logic             wd_expire;

   // Round-robin search starting one past the last granted port
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_PORTS);
         if (!pick_vld && in_valid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign last_beat = in_valid[gnt] && out_ready && in_last[gnt];

`ifdef ARB_WATCHDOG_EN
   logic [15:0] wd_cnt;

   // Counts only upstream starvation; a downstream stall keeps in_valid high and clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= '0;
      else if (state == XFER && !in_valid[gnt])
         wd_cnt <= wd_cnt + 16'd1;
      else
         wd_cnt <= '0;
   end

   assign wd_expire = (state == XFER) && !in_valid[gnt] && (wd_cnt == 16'(TIMEOUT - 1));
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= IDX_W'(NUM_PORTS - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_vld) begin
            gnt <= pick_idx;
            ptr <= pick_idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_vld)
               state_nxt = XFER;
         end
         XFER: begin
            if (last_beat)
               state_nxt = IDLE;
`ifdef ARB_WATCHDOG_EN
            else if (wd_expire)
               state_nxt = ABORT;
`endif
         end
`ifdef ARB_WATCHDOG_EN
         ABORT: begin
            if (out_ready)
               state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // XFER is a zero-latency pass-through; IDLE and ABORT drive constants
   always_comb begin
      in_ready  = '0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      out_err   = 1'b0;
      case (state)
         XFER: begin
            out_valid     = in_valid[gnt];
            out_data      = in_data[{gnt, 3'b000} +: 8];
            out_last      = in_last[gnt];
            in_ready[gnt] = out_ready;
         end
`ifdef ARB_WATCHDOG_EN
         ABORT: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_err   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign out_port = gnt;
   assign busy     = (state != IDLE);

   logic unused_wd;
   assign unused_wd = wd_expire;

endmodule

// File: tb/tb_mac_rx_frame_arbiter.sv
// Directed bench for mac_rx_frame_arbiter; watchdog expectations follow ARB_WATCHDOG_EN.
module tb_mac_rx_frame_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_last = '0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_port;
   logic        out_err;
   logic        out_ready = 1'b0;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-port frame sources: mode 0 = last on final byte, 1 = every byte last, 2 = never last
   int         src_len  [4];
   int         src_cnt  [4];
   int         src_mode [4];
   logic [7:0] src_base [4];

   mac_rx_frame_arbiter #(.NUM_PORTS(4), .IDX_W(2), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_port(out_port), .out_err(out_err), .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] pk(logic v, logic [7:0] d, logic l, logic [1:0] p,
                                      logic e, logic b, logic [3:0] r);
      return {v, d, l, p, e, b, r};
   endfunction

   function automatic logic [17:0] obs();
      return {out_valid, out_data, out_last, out_port, out_err, busy, in_ready};
   endfunction

   function automatic void drive_srcs();
      for (int k = 0; k < 4; k++) begin
         in_valid[k]       = (src_cnt[k] < src_len[k]);
         in_data[8*k +: 8] = src_base[k] + 8'(src_cnt[k]);
         in_last[k]        = (src_mode[k] == 1) ? 1'b1 :
                             (src_mode[k] == 2) ? 1'b0 : (src_cnt[k] == src_len[k] - 1);
      end
   endfunction

   function automatic void set_src(int k, int len, int mode, logic [7:0] base);
      src_len[k]  = len;
      src_cnt[k]  = 0;
      src_mode[k] = mode;
      src_base[k] = base;
   endfunction

   task automatic step_srcs();
      logic [3:0] r;
      logic [3:0] v;
      r = in_ready;
      v = in_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         if (r[k] && v[k]) src_cnt[k]++;
      drive_srcs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) set_src(k, 0, 0, 8'h00);
      drive_srcs();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) set_src(k, 2, 0, 8'h55);
      drive_srcs();
      out_ready = 1'b1;
      #2;
      n_checks++;
      if (obs() !== pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000)) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs(), pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000));
      end
      do_reset();
      #1;
      n_checks++;
      if (obs() !== pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000)) begin
         n_fail++;
         $display("FAIL reset_idle: got %h expected %h", obs(), pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000));
      end
   endtask

   task automatic test_single_frame();
      logic [17:0] exp [5];
      do_reset();
      set_src(1, 3, 0, 8'hA0);
      drive_srcs();
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'hA0, 0, 2'd1, 0, 1, 4'b0010);
      exp[2] = pk(1, 8'hA1, 0, 2'd1, 0, 1, 4'b0010);
      exp[3] = pk(1, 8'hA2, 1, 2'd1, 0, 1, 4'b0010);
      exp[4] = pk(0, 8'h00, 0, 2'd1, 0, 0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL single_frame cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         step_srcs();
      end
   endtask

   task automatic test_two_ports();
      logic [17:0] exp [11];
      do_reset();
      set_src(0, 4, 0, 8'h10);
      set_src(2, 4, 0, 8'h20);
      drive_srcs();
      exp[0]  = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1]  = pk(1, 8'h10, 0, 2'd0, 0, 1, 4'b0001);
      exp[2]  = pk(1, 8'h11, 0, 2'd0, 0, 1, 4'b0001);
      exp[3]  = pk(1, 8'h12, 0, 2'd0, 0, 1, 4'b0001);
      exp[4]  = pk(1, 8'h13, 1, 2'd0, 0, 1, 4'b0001);
      exp[5]  = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[6]  = pk(1, 8'h20, 0, 2'd2, 0, 1, 4'b0100);
      exp[7]  = pk(1, 8'h21, 0, 2'd2, 0, 1, 4'b0100);
      exp[8]  = pk(1, 8'h22, 0, 2'd2, 0, 1, 4'b0100);
      exp[9]  = pk(1, 8'h23, 1, 2'd2, 0, 1, 4'b0100);
      exp[10] = pk(0, 8'h00, 0, 2'd2, 0, 0, 4'b0000);
      for (int i = 0; i < 11; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL two_ports cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         step_srcs();
      end
   endtask

   task automatic test_round_robin();
      logic [17:0] exp [10];
      do_reset();
      set_src(0, 8, 1, 8'h30);
      set_src(1, 8, 1, 8'h40);
      set_src(2, 8, 1, 8'h50);
      set_src(3, 8, 1, 8'h60);
      drive_srcs();
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'h30, 1, 2'd0, 0, 1, 4'b0001);
      exp[2] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[3] = pk(1, 8'h40, 1, 2'd1, 0, 1, 4'b0010);
      exp[4] = pk(0, 8'h00, 0, 2'd1, 0, 0, 4'b0000);
      exp[5] = pk(1, 8'h50, 1, 2'd2, 0, 1, 4'b0100);
      exp[6] = pk(0, 8'h00, 0, 2'd2, 0, 0, 4'b0000);
      exp[7] = pk(1, 8'h60, 1, 2'd3, 0, 1, 4'b1000);
      exp[8] = pk(0, 8'h00, 0, 2'd3, 0, 0, 4'b0000);
      exp[9] = pk(1, 8'h31, 1, 2'd0, 0, 1, 4'b0001);
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL round_robin cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         step_srcs();
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] exp [7];
      logic        rdy [7];
      logic [7:0]  rxq [$];
      do_reset();
      set_src(3, 3, 0, 8'h70);
      drive_srcs();
      rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'h70, 0, 2'd3, 0, 1, 4'b1000);
      exp[2] = pk(1, 8'h71, 0, 2'd3, 0, 1, 4'b0000);
      exp[3] = pk(1, 8'h71, 0, 2'd3, 0, 1, 4'b0000);
      exp[4] = pk(1, 8'h71, 0, 2'd3, 0, 1, 4'b1000);
      exp[5] = pk(1, 8'h72, 1, 2'd3, 0, 1, 4'b1000);
      exp[6] = pk(0, 8'h00, 0, 2'd3, 0, 0, 4'b0000);
      for (int i = 0; i < 7; i++) begin
         out_ready = rdy[i];
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL backpressure cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         if (out_valid && out_ready) rxq.push_back(out_data);
         step_srcs();
      end
      out_ready = 1'b1;
      n_checks++;
      if (rxq.size() != 3) begin
         n_fail++;
         $display("FAIL backpressure_count: got %0d bytes expected 3", rxq.size());
      end
      for (int j = 0; j < 3; j++) begin
         if (j < rxq.size()) begin
            n_checks++;
            if (rxq[j] !== 8'h70 + 8'(j)) begin
               n_fail++;
               $display("FAIL backpressure_byte %0d: got %h expected %h", j, rxq[j], 8'h70 + 8'(j));
            end
         end
      end
   endtask

   task automatic test_watchdog();
      logic [17:0] exp [8];
      do_reset();
      set_src(2, 1, 2, 8'h80);
      drive_srcs();
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'h80, 0, 2'd2, 0, 1, 4'b0100);
      exp[2] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
      exp[3] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
      exp[4] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
      exp[5] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
`ifdef ARB_WATCHDOG_EN
      exp[6] = pk(1, 8'h00, 1, 2'd2, 1, 1, 4'b0000);
      exp[7] = pk(0, 8'h00, 0, 2'd2, 0, 0, 4'b0000);
`else
      exp[6] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
      exp[7] = pk(0, 8'h81, 0, 2'd2, 0, 1, 4'b0100);
`endif
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL watchdog cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         step_srcs();
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [17:0] exp [3];
      do_reset();
      set_src(1, 4, 0, 8'hB0);
      drive_srcs();
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'hB0, 0, 2'd1, 0, 1, 4'b0010);
      exp[2] = pk(1, 8'hB1, 0, 2'd1, 0, 1, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL reset_mid pre cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         if (i < 2) step_srcs();
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs() !== pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000)) begin
         n_fail++;
         $display("FAIL reset_mid async: got %h expected %h", obs(), pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_src(1, 0, 0, 8'h00);
      set_src(3, 1, 0, 8'h90);
      drive_srcs();
      exp[0] = pk(0, 8'h00, 0, 2'd0, 0, 0, 4'b0000);
      exp[1] = pk(1, 8'h90, 1, 2'd3, 0, 1, 4'b1000);
      exp[2] = pk(0, 8'h00, 0, 2'd3, 0, 0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL reset_mid post cyc %0d: got %h expected %h", i, obs(), exp[i]);
         end
         step_srcs();
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_two_ports();
      test_round_robin();
      test_backpressure();
      test_watchdog();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
